// File: rtl/divider_4.sv
// divider_4: sequential 8-bit by 4-bit unsigned restoring divider.
//
// Each accepted request resolves one quotient bit per clock, MSB first.
// The division takes eight steps. The result is held on the outputs until
// the next division completes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      division request, accepted only when idle
//   dividend   8-bit unsigned dividend, sampled on the accepting edge
//   divisor    4-bit unsigned divisor, sampled on the accepting edge
//   busy       high while a division is in progress
//   done       one-cycle pulse when quotient/remainder/dz update
//   quotient   8-bit quotient, held until the next done
//   remainder  4-bit remainder, held until the next done
//   dz         divide-by-zero flag for the held result
module divider_4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       dz
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  // Datapath state
  logic [7:0] shift_q;      // dividend bits shift out, quotient bits shift in
  logic [3:0] div_q;        // latched divisor
  logic [3:0] rem_q;        // partial remainder, always < divisor after a step
  logic [2:0] cnt_q;        // steps remaining minus one
  logic       zero_q;       // latched divisor == 0

  // Result registers
  logic [7:0] quotient_q;
  logic [3:0] remainder_q;
  logic       dz_q;
  logic       done_q;

  // Control decodes
  logic accept;
  logic run;
  logic last_step;

  // Step datapath
  logic [4:0] rem_shift;
  logic [4:0] div_ext;
  logic       q_bit;
  logic [3:0] rem_step;
  logic [7:0] shift_step;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q == 3'd0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs and decodes
  //--------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    accept    = 1'b0;
    run       = 1'b0;
    last_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        accept = start;
      end
      StRun: begin
        busy      = 1'b1;
        run       = 1'b1;
        last_step = (cnt_q == 3'd0);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // One restoring step
  //--------------------------------------------------------------------------
  // R' is 5 bits wide so the shifted-in bit never overflows. When R' >= divisor
  // the difference is below the divisor, so it fits in 4 bits. When R' < divisor
  // R'[4] is necessarily 0. Either way the stored remainder needs only 4 bits.
  always_comb begin
    rem_shift  = {rem_q, shift_q[7]};
    div_ext    = {1'b0, div_q};
    q_bit      = (rem_shift >= div_ext);
    rem_step   = q_bit ? (rem_shift[3:0] - div_q) : rem_shift[3:0];
    shift_step = {shift_q[6:0], q_bit};
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 8'h00;
      div_q   <= 4'h0;
      rem_q   <= 4'h0;
      cnt_q   <= 3'd0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      shift_q <= dividend;
      div_q   <= divisor;
      rem_q   <= 4'h0;
      cnt_q   <= 3'd7;
      zero_q  <= (divisor == 4'h0);
    end else if (run) begin
      shift_q <= shift_step;
      rem_q   <= rem_step;
      cnt_q   <= cnt_q - 3'd1;
    end
  end

  //--------------------------------------------------------------------------
  // Result registers: update only on the completing step
  //--------------------------------------------------------------------------
  // With a zero divisor every step "subtracts" zero. After eight shifts the
  // remainder therefore holds the low dividend nibble, which is the required
  // forced remainder. The quotient is forced explicitly rather than relying on
  // the all-ones pattern the steps would also produce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient_q  <= 8'h00;
      remainder_q <= 4'h0;
      dz_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= last_step;
      if (last_step) begin
        quotient_q  <= zero_q ? 8'hFF : shift_step;
        remainder_q <= rem_step;
        dz_q        <= zero_q;
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_divider_4.sv
// tb_divider_4: self-checking bench for divider_4.
// Table-driven directed divisions, hand-written multi-cycle corner cases and
// an exhaustive operand sweep. Expected results are queued when a request is
// driven; a monitor pops and compares them on every done pulse.
module tb_divider_4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dz;

  divider_4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'h0) begin
      e.q = 8'hFF;
      e.r = a[3:0];
      e.z = 1'b1;
    end else begin
      e.q = a / {4'h0, b};
      e.r = 4'(a % {4'h0, b});
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor: one comparison per done pulse.
  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      check("done_while_busy", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with q=%0h r=%0h dz=%0b, expected none",
                 quotient, remainder, dz);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", {19'd0, quotient, remainder, dz}, {19'd0, e.q, e.r, e.z});
      end
    end
  end

  // Drive a request at a negedge; returns just after the accepting edge.
  task automatic start_div(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 24);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d edges, expected done", lat);
    end
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = '{a: 8'd143, b: 4'd11, q: 8'd13,  r: 4'd0, z: 1'b0};
    vecs[1] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, z: 1'b0};
    vecs[2] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0, z: 1'b0};
    vecs[3] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, z: 1'b0};
    vecs[4] = '{a: 8'd5,   b: 4'd9,  q: 8'd0,   r: 4'd5, z: 1'b0};
    vecs[5] = '{a: 8'hA7,  b: 4'd0,  q: 8'hFF,  r: 4'h7, z: 1'b1};
    vecs[6] = '{a: 8'h10,  b: 4'd4,  q: 8'd4,   r: 4'd0, z: 1'b0};

    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {18'd0, busy, done, quotient, remainder, dz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: constants checked by the monitor, latency checked here.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start    = 1'b1;
      dividend = vecs[i].a;
      divisor  = vecs[i].b;
      exp_q.push_back('{q: vecs[i].q, r: vecs[i].r, z: vecs[i].z});
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_done(lat);
      check("latency", lat, 32'd8);
    end

    // start at T3 with other operands must be ignored.
    start_div(8'd200, 4'd7);
    @(posedge clk);
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("latency_ignored_start", lat, 32'd5);
    @(posedge clk);
    #1;
    check("no_restart_after_ignored", {31'd0, busy}, 32'd0);

    // Back-to-back: start held high, operands changed on the done cycle.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd143;
    divisor  = 4'd11;
    exp_q.push_back(model(8'd143, 4'd11));
    @(posedge clk);
    #1;
    wait_done(lat);
    check("b2b_first_latency", lat, 32'd8);
    dividend = 8'd100;
    divisor  = 4'd3;
    exp_q.push_back('{q: 8'd33, r: 4'd1, z: 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("b2b_second_latency", lat, 32'd8);

    // Reset mid-RUN: outputs clear at once, the in-flight result is dropped.
    start_div(8'd143, 4'd11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {18'd0, busy, done, quotient, remainder, dz}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("no_done_after_reset", seen, 32'd0);
    start_div(8'd200, 4'd7);
    wait_done(lat);
    check("post_reset_latency", lat, 32'd8);

    // Exhaustive sweep against the reference model.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_div(8'(a), 4'(b));
        wait_done(lat);
        if (lat != 8) check("sweep_latency", lat, 32'd8);
      end
    end

    @(posedge clk);
    #2;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
